// File: rtl/por_seq.sv
// Power-on-reset sequencer: per-unit reset pulse FSMs with retry lockout,
// plus a break-before-make bus-enable selector driven by the primary select.
`timescale 1ns/1ps
module por_seq #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned RECOVER_CYCLES = 64,
  parameter int unsigned BBM_CYCLES     = 4,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] prime,
  input  logic [1:0] por,
  output logic [1:0] unit_rst,
  output logic [1:0] out_en,
  output logic [1:0] lockout,
  output logic       prime_err
);

  localparam int unsigned CH_TMAX = (RST_CYCLES > RECOVER_CYCLES) ? RST_CYCLES : RECOVER_CYCLES;
  localparam int unsigned CTW     = $clog2(CH_TMAX + 1);
  localparam int unsigned GTW     = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;

  localparam logic [CTW-1:0] RST_LOAD = CTW'(RST_CYCLES - 1);
  localparam logic [CTW-1:0] REC_LOAD = CTW'(RECOVER_CYCLES - 1);
  localparam logic [GTW-1:0] GAP_LOAD = GTW'(BBM_CYCLES - 1);

  typedef enum logic [1:0] {C_IDLE, C_RST, C_RECOVER, C_LOCKED} chan_state_e;
  typedef enum logic [1:0] {S_NONE, S_SEL0, S_SEL1, S_GAP} sel_state_e;

  // Inputs come from another block; register them once so every FSM sees
  // the same sampled value and outputs react one edge after sampling.
  logic [1:0] prime_q;
  logic [1:0] por_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prime_q <= '0;
      por_q   <= '0;
    end else begin
      prime_q <= prime;
      por_q   <= por;
    end
  end

  logic [1:0] chan_idle;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      chan_state_e    state_q;
      logic [CTW-1:0] timer_q;
      logic [1:0]     retry_q;
      logic           rst_q;
      logic           lock_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= C_IDLE;
          timer_q <= '0;
          retry_q <= '0;
          rst_q   <= 1'b0;
          lock_q  <= 1'b0;
        end else begin
          case (state_q)
            C_IDLE: begin
              if (por_q[gi]) begin
                if (32'(retry_q) < MAX_RETRY) begin
                  state_q <= C_RST;
                  timer_q <= RST_LOAD;
                  rst_q   <= 1'b1;
                  if (retry_q != 2'd3) retry_q <= retry_q + 2'd1;
                end else begin
                  state_q <= C_LOCKED;
                  rst_q   <= 1'b1;
                  lock_q  <= 1'b1;
                end
              end else if (prime_q[gi]) begin
                retry_q <= '0;
              end
            end
            C_RST: begin
              if (timer_q == '0) begin
                state_q <= C_RECOVER;
                timer_q <= REC_LOAD;
                rst_q   <= 1'b0;
              end else begin
                timer_q <= timer_q - CTW'(1);
              end
            end
            C_RECOVER: begin
              if (timer_q == '0) state_q <= C_IDLE;
              else               timer_q <= timer_q - CTW'(1);
            end
            C_LOCKED: state_q <= C_LOCKED;
            default:  state_q <= C_IDLE;
          endcase
        end
      end

      assign chan_idle[gi] = (state_q == C_IDLE);
      assign unit_rst[gi]  = rst_q;
      assign lockout[gi]   = lock_q;
    end
  endgenerate

  // A channel about to leave IDLE (por pending) is already an invalid target,
  // so por overrides prime in the same edge that starts the reset pulse.
  logic [1:0] valid;
  assign valid = chan_idle & ~por_q & ~lockout;

  sel_state_e target;
  always_comb begin
    target = S_NONE;
    if (prime_q == 2'b01 && valid[0])      target = S_SEL0;
    else if (prime_q == 2'b10 && valid[1]) target = S_SEL1;
  end

  function automatic logic [1:0] sel_oe(input sel_state_e s);
    return {s == S_SEL1, s == S_SEL0};
  endfunction

  sel_state_e     sel_q;
  logic [GTW-1:0] gap_q;
  logic [1:0]     out_en_q;
  logic           prime_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= S_NONE;
      gap_q       <= '0;
      out_en_q    <= '0;
      prime_err_q <= 1'b0;
    end else begin
      prime_err_q <= prime_err_q | (prime_q == 2'b11);
      case (sel_q)
        S_NONE: begin
          sel_q    <= target;
          out_en_q <= sel_oe(target);
        end
        S_SEL0: begin
          if (target != S_SEL0) begin
            out_en_q <= '0;
            if (!valid[0]) begin
              sel_q <= S_NONE;
            end else begin
              sel_q <= S_GAP;
              gap_q <= GAP_LOAD;
            end
          end
        end
        S_SEL1: begin
          if (target != S_SEL1) begin
            out_en_q <= '0;
            if (!valid[1]) begin
              sel_q <= S_NONE;
            end else begin
              sel_q <= S_GAP;
              gap_q <= GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            sel_q    <= target;
            out_en_q <= sel_oe(target);
          end else begin
            gap_q <= gap_q - GTW'(1);
          end
        end
        default: begin
          sel_q    <= S_NONE;
          out_en_q <= '0;
        end
      endcase
    end
  end

  assign out_en    = out_en_q;
  assign prime_err = prime_err_q;

endmodule

// File: tb/tb_por_seq.sv
// Scoreboard bench for por_seq: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_por_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] prime;
  logic [1:0] por;
  logic [1:0] unit_rst;
  logic [1:0] out_en;
  logic [1:0] lockout;
  logic       prime_err;

  always #5 clk = ~clk;

  por_seq #(
    .RST_CYCLES    (16),
    .RECOVER_CYCLES(64),
    .BBM_CYCLES    (4),
    .MAX_RETRY     (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .prime    (prime),
    .por      (por),
    .unit_rst (unit_rst),
    .out_en   (out_en),
    .lockout  (lockout),
    .prime_err(prime_err)
  );

  localparam int F_RST = 0;
  localparam int F_OE  = 1;
  localparam int F_LK  = 2;
  localparam int F_PE  = 3;

  typedef struct {
    int         cyc;
    string      tag;
    int         field;
    logic [1:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", tag, obs, exp, cyc_cnt);
    end
  endtask

  // Keep the queue ordered by cycle so the monitor only looks at its head.
  task automatic expect_at(input int c, input string tag, input int field, input logic [1:0] v);
    exp_t e;
    int   idx;
    e.cyc   = c;
    e.tag   = tag;
    e.field = field;
    e.val   = v;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].cyc > c) idx--;
    sb.insert(idx, e);
  endtask

  function automatic logic [1:0] field_val(input int f);
    case (f)
      F_RST:   return unit_rst;
      F_OE:    return out_en;
      F_LK:    return lockout;
      default: return {1'b0, prime_err};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e_mon = sb.pop_front();
      chk($sformatf("%s@%0d", e_mon.tag, e_mon.cyc), field_val(e_mon.field), e_mon.val);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_to(input int c);
    while (cyc_cnt < c) @(negedge clk);
  endtask

  task automatic tx_note(input string name);
    $display("tx %s at cycle %0d", name, cyc_cnt);
  endtask

  // Called on a negedge; asserts reset for one edge and expects all-zero outputs.
  task automatic do_reset();
    int c;
    reset = 1'b1;
    c = cyc_cnt;
    for (int f = 0; f < 4; f++) expect_at(c + 1, "reset", f, 2'b00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish (cycle %0d)", cyc_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int e0;
    int t;
    logic u0;

    reset = 1'b1;
    prime = 2'b00;
    por   = 2'b00;
    tick(2);

    tx_note("reset_then_prime0");
    do_reset();
    c = cyc_cnt;
    prime = 2'b01;
    expect_at(c + 1, "sel0_lat", F_OE, 2'b00);
    expect_at(c + 2, "sel0", F_OE, 2'b01);
    expect_at(c + 2, "sel0_rst", F_RST, 2'b00);
    tick(4);

    tx_note("bbm_0_to_1");
    c = cyc_cnt;
    prime = 2'b10;
    expect_at(c + 1, "bbm_hold", F_OE, 2'b01);
    for (int k = 2; k <= 5; k++) expect_at(c + k, "bbm_gap", F_OE, 2'b00);
    expect_at(c + 6, "bbm_sel1", F_OE, 2'b10);
    tick(8);

    tx_note("por_pulse_ch0");
    prime = 2'b01;
    tick(8);
    c = cyc_cnt;
    por = 2'b01;
    expect_at(c + 1, "por_pre_oe", F_OE, 2'b01);
    expect_at(c + 1, "por_pre_rst", F_RST, 2'b00);
    for (int k = c + 2; k <= c + 17; k++) expect_at(k, "por_rst", F_RST, 2'b01);
    for (int k = c + 18; k <= c + 85; k++) expect_at(k, "por_rec", F_RST, 2'b00);
    for (int k = c + 2; k <= c + 82; k++) expect_at(k, "por_oe_off", F_OE, 2'b00);
    expect_at(c + 83, "por_oe_back", F_OE, 2'b01);
    tick(1);
    por = 2'b00;
    tick_to(c + 30);
    por = 2'b01;
    tick(1);
    por = 2'b00;
    tick_to(c + 88);

    tx_note("por_held_lockout");
    do_reset();
    c = cyc_cnt;
    prime = 2'b10;
    por   = 2'b01;
    e0 = c + 2;
    expect_at(c + 1, "lk_pre", F_RST, 2'b00);
    // Each retry: 16 reset cycles, 64 recover cycles, one IDLE cycle.
    for (int k = e0; k <= e0 + 255; k++) begin
      t  = k - e0;
      u0 = (t >= 243) ? 1'b1 : ((t % 81) < 16);
      expect_at(k, "lk_rst", F_RST, {1'b0, u0});
      expect_at(k, "lk_flag", F_LK, {1'b0, t >= 243});
      expect_at(k, "lk_oe1", F_OE, 2'b10);
    end
    tick_to(e0 + 246);
    por = 2'b00;
    tick_to(e0 + 256);

    tx_note("prime_err");
    do_reset();
    c = cyc_cnt;
    prime = 2'b11;
    expect_at(c + 1, "perr_pre", F_PE, 2'b00);
    for (int k = c + 2; k <= c + 8; k++) expect_at(k, "perr_sticky", F_PE, 2'b01);
    for (int k = c + 1; k <= c + 8; k++) expect_at(k, "perr_oe", F_OE, 2'b00);
    tick(1);
    prime = 2'b00;
    tick_to(c + 9);

    tx_note("reset_mid_rst");
    do_reset();
    c = cyc_cnt;
    por = 2'b01;
    expect_at(c + 1, "mid_pre", F_RST, 2'b00);
    for (int k = c + 2; k <= c + 9; k++) expect_at(k, "mid_rst", F_RST, 2'b01);
    tick(1);
    por = 2'b00;
    tick_to(c + 9);
    do_reset();
    c = cyc_cnt;
    por = 2'b01;
    expect_at(c + 1, "re_pre", F_RST, 2'b00);
    for (int k = c + 2; k <= c + 17; k++) expect_at(k, "re_rst", F_RST, 2'b01);
    expect_at(c + 18, "re_end", F_RST, 2'b00);
    tick(1);
    por = 2'b00;
    tick_to(c + 20);

    tx_note("por_both");
    do_reset();
    c = cyc_cnt;
    por = 2'b11;
    expect_at(c + 1, "both_pre", F_RST, 2'b00);
    for (int k = c + 2; k <= c + 17; k++) expect_at(k, "both_rst", F_RST, 2'b11);
    expect_at(c + 18, "both_end", F_RST, 2'b00);
    tick(1);
    por = 2'b00;
    tick_to(c + 20);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("sb_drain", {1'b0, sb.size() != 0}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/por_seq.md
POR_SEQ -- requirements
Module: por_seq

Interface
REQ-001 Parameter RST_CYCLES, default 16: clock cycles a unit reset pulse is held.
REQ-002 Parameter RECOVER_CYCLES, default 64: post-reset cycles during which por is ignored.
REQ-003 Parameter BBM_CYCLES, default 4: break-before-make gap, in cycles, between output-enable changes.
REQ-004 Parameter MAX_RETRY, default 3: number of reset attempts before a channel locks out.
REQ-005 clk  input  1: single system clock; all logic is on the rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 prime  input  2: one-hot primary select from the fdu block; bit i selects unit i.
REQ-008 por  input  2: level power-on-reset request from the fdu block, one bit per unit.
REQ-009 unit_rst  output  2: registered reset drive to unit i.
REQ-010 out_en  output  2: registered bus-enable for unit i; at most one bit is set.
REQ-011 lockout  output  2: sticky flag; unit i has exhausted its retries.
REQ-012 prime_err  output  1: sticky flag; prime==11 was seen.

Function
REQ-013 Each channel i SHALL run an independent FSM with states IDLE, RST, RECOVER and LOCKED.
REQ-014 IDLE with por[i]=1: if retry_cnt[i]<MAX_RETRY, go to RST next cycle and increment retry_cnt[i]; otherwise go to LOCKED.
REQ-015 RST: unit_rst[i]=1 for exactly RST_CYCLES cycles, then go to RECOVER; por[i] in RST neither extends nor restarts the pulse.
REQ-016 RECOVER: unit_rst[i]=0; por[i] is ignored for RECOVER_CYCLES cycles, then go to IDLE; if por[i] is still 1 on the first IDLE cycle, REQ-014 applies.
REQ-017 LOCKED: unit_rst[i]=1 and lockout[i]=1, held until reset; no other exit.
REQ-018 retry_cnt[i] is 2 bits, saturating; it clears when prime[i]=1 and the channel is IDLE for 1 cycle with por[i]=0.
REQ-019 The two channels SHALL be fully independent, including when por arrives on both in the same cycle.
REQ-020 The select FSM SHALL have states NONE, SEL0, SEL1 and GAP; out_en[i]=1 only in SELi.
REQ-021 Target function: prime=01 gives target SEL0; prime=10 gives SEL1; 00 or 11 gives NONE. A channel not in IDLE, or with lockout set, is never a valid target; that case maps to NONE.
REQ-022 From SEL0 or SEL1, when the target differs from the current state, go to GAP with all out_en=0 for BBM_CYCLES cycles, then enter the target as evaluated on the last GAP cycle.
REQ-023 From NONE, a valid target is entered directly on the next cycle with no gap.
REQ-024 In GAP, a target change extends nothing; the gap length is fixed.
REQ-025 Latency: a prime or por change sampled on cycle n affects unit_rst or out_en no earlier than the edge ending cycle n+1.
REQ-026 prime_err sets on any cycle with prime=11 and clears only on reset.
REQ-027 If por[i] and prime[i] are 1 in the same cycle, por wins: the channel leaves IDLE and out_en[i] drops within 1 cycle, without a gap.

Reset
REQ-028 Synchronous reset, at any time including mid-RST or mid-GAP: channel FSMs go to IDLE, retry_cnt=0, select FSM goes to NONE.
REQ-029 Outputs on the cycle after reset: unit_rst=00, out_en=00, lockout=00, prime_err=0; all timers are cleared.

Verification
REQ-030 Reset, then prime=01 with por=00 -> out_en=01 on the 2nd edge; unit_rst=00.
REQ-031 In SEL0, prime 01->10 -> out_en=00 for 4 cycles, then out_en=10; never 11.
REQ-032 por=01 for 1 cycle -> unit_rst[0]=1 for exactly 16 cycles; out_en[0] drops within 1 cycle; a por[0] pulse at cycle 30 after the rising edge is ignored.
REQ-033 por[0] held high -> 3 reset pulses, each 16 cycles with 64-cycle recover gaps, then lockout[0]=1 and unit_rst[0]=1 held; channel 1 is unaffected.
REQ-034 prime=11 for 1 cycle -> prime_err=1 sticky, out_en=00; reset clears it.
REQ-035 Reset asserted mid-RST (cycle 8) -> next cycle unit_rst=00, retry count 0; a following por gives a full 16-cycle pulse.
